counter_timer_ctrl: RTL and testbench

// Sequencer for one external WIDTH-bit counter (clr/en/we/dat load port, dat readback).

---
 rtl/counter_timer_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_counter_timer_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_timer_ctrl.sv
// -----------------------------------------------------------------------------
// counter_timer_ctrl
//
// Sequencer that drives one external WIDTH-bit counter (clear / increment /
// load port, value read back on cnt_dat_i) so that the pair behaves as a
// programmable interval timer. It provides a prescaler, one-shot and periodic
// modes, a sticky interrupt flag and a sticky overrun flag.
//
// Ports
//   clk_i, rst_n_i    clock (rising edge) and asynchronous active-low reset
//   start_i           start pulse; latches the config inputs (IDLE/DONE only)
//   stop_i            abort; wins over start_i in the same cycle
//   clear_i           counter clear request, honoured in IDLE only
//   mode_i            0 = one-shot, 1 = periodic
//   load_val_i        counter start value
//   term_val_i        terminal value
//   psc_i             prescale divisor minus 1 (tick every psc_i+1 cycles)
//   irq_ack_i         clears irq_o and overrun_o
//   cnt_dat_i         current counter value
//   cnt_clr_o         counter clear
//   cnt_en_o          counter increment enable
//   cnt_we_o          counter load strobe
//   cnt_dat_o         counter load value (0 whenever cnt_we_o is 0)
//   busy_o            high in LOAD and RUN
//   done_o            one-cycle pulse after one-shot completion
//   irq_o             sticky terminal-event flag
//   overrun_o         sticky: terminal event while irq_o was already set
//   state_o           current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module counter_timer_ctrl #(
   parameter int WIDTH     = 8,
   parameter int PSC_WIDTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic                 clear_i,
   input  logic                 mode_i,
   input  logic [WIDTH-1:0]     load_val_i,
   input  logic [WIDTH-1:0]     term_val_i,
   input  logic [PSC_WIDTH-1:0] psc_i,
   input  logic                 irq_ack_i,
   input  logic [WIDTH-1:0]     cnt_dat_i,
   output logic                 cnt_clr_o,
   output logic                 cnt_en_o,
   output logic                 cnt_we_o,
   output logic [WIDTH-1:0]     cnt_dat_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 irq_o,
   output logic                 overrun_o,
   output logic [1:0]           state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 state;
   logic [WIDTH-1:0]       load_sh;
   logic [WIDTH-1:0]       term_sh;
   logic                   mode_sh;
   logic [PSC_WIDTH-1:0]   psc_sh;
   logic [PSC_WIDTH-1:0]   psc_cnt;
   logic                   busy_q;
   logic                   done_q;
   logic                   irq_q;
   logic                   overrun_q;

   logic                   accept;
   logic                   run_live;
   logic                   tick;
   logic                   at_term;
   logic                   term_event;

   localparam logic [PSC_WIDTH-1:0] PSC_ONE = {{(PSC_WIDTH-1){1'b0}}, 1'b1};

   // A start is only taken when the timer is not active; stop always wins.
   assign accept     = ((state == S_IDLE) || (state == S_DONE)) && start_i && !stop_i;
   // RUN cycles in which stop is not requested are the only ones that may
   // touch the counter from the run path.
   assign run_live   = (state == S_RUN) && !stop_i;
   assign tick       = (psc_cnt == psc_sh);
   assign at_term    = (cnt_dat_i == term_sh);
   assign term_event = run_live && tick && at_term;

   // Counter-side strobes are decoded from registered state so the counter
   // sees them in the same cycle as the decision.
   always_comb begin
      cnt_en_o  = 1'b0;
      cnt_we_o  = 1'b0;
      cnt_dat_o = '0;
      if ((state == S_LOAD) && !stop_i) begin
         cnt_we_o = 1'b1;
      end else if (run_live && tick) begin
         if (!at_term) begin
            cnt_en_o = 1'b1;
         end else if (mode_sh) begin
            // Periodic reload happens in the event cycle itself: no gap.
            cnt_we_o = 1'b1;
         end
      end
      if (cnt_we_o) begin
         cnt_dat_o = load_sh;
      end
   end

   // Gated with the reset so every output reads 0 while reset is asserted.
   assign cnt_clr_o = rst_n_i && (state == S_IDLE) && clear_i;

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign irq_o     = irq_q;
   assign overrun_o = overrun_q;
   assign state_o   = state;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= S_IDLE;
         load_sh   <= '0;
         term_sh   <= '0;
         mode_sh   <= 1'b0;
         psc_sh    <= '0;
         psc_cnt   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         irq_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q <= 1'b0;

         // Set has priority over acknowledge for the interrupt flag; an
         // acknowledged event cannot also count as an overrun.
         if (term_event) begin
            irq_q <= 1'b1;
         end else if (irq_ack_i) begin
            irq_q <= 1'b0;
         end
         if (term_event && irq_q && !irq_ack_i) begin
            overrun_q <= 1'b1;
         end else if (irq_ack_i) begin
            overrun_q <= 1'b0;
         end

         if (accept) begin
            load_sh <= load_val_i;
            term_sh <= term_val_i;
            mode_sh <= mode_i;
            psc_sh  <= psc_i;
         end

         case (state)
            S_IDLE: begin
               if (accept) begin
                  state  <= S_LOAD;
                  busy_q <= 1'b1;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            S_LOAD: begin
               psc_cnt <= '0;
               if (stop_i) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  state  <= S_RUN;
                  busy_q <= 1'b1;
               end
            end
            S_RUN: begin
               if (stop_i) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  psc_cnt <= tick ? '0 : (psc_cnt + PSC_ONE);
                  if (term_event && !mode_sh) begin
                     state  <= S_DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (accept) begin
                  state  <= S_LOAD;
                  busy_q <= 1'b1;
               end else begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_timer_ctrl
//
// Directed bench for counter_timer_ctrl. A small behavioural counter stands in
// for the external counter datapath. Inputs are driven on the falling edge and
// outputs are sampled 1 time unit later, half a period away from the active
// edge. Expected output words are hand-computed per cycle.
//
// Output word layout: {clr, en, we, busy, done, irq, ovr, dat[7:0]}
// -----------------------------------------------------------------------------
module tb_counter_timer_ctrl;

   localparam int WIDTH     = 8;
   localparam int PSC_WIDTH = 4;

   logic                 clk_i = 1'b0;
   logic                 rst_n_i = 1'b0;
   logic                 start_i = 1'b0;
   logic                 stop_i = 1'b0;
   logic                 clear_i = 1'b0;
   logic                 mode_i = 1'b0;
   logic [WIDTH-1:0]     load_val_i = '0;
   logic [WIDTH-1:0]     term_val_i = '0;
   logic [PSC_WIDTH-1:0] psc_i = '0;
   logic                 irq_ack_i = 1'b0;
   logic [WIDTH-1:0]     cnt_dat_i;
   logic                 cnt_clr_o;
   logic                 cnt_en_o;
   logic                 cnt_we_o;
   logic [WIDTH-1:0]     cnt_dat_o;
   logic                 busy_o;
   logic                 done_o;
   logic                 irq_o;
   logic                 overrun_o;
   logic [1:0]           state_o;

   int vec_cnt  = 0;
   int miscmp   = 0;

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- external counter model ----------------
   logic [WIDTH-1:0] cnt_q = '0;
   always @(posedge clk_i) begin
      if (cnt_clr_o)      cnt_q <= '0;
      else if (cnt_we_o)  cnt_q <= cnt_dat_o;
      else if (cnt_en_o)  cnt_q <= cnt_q + 8'd1;
   end
   assign cnt_dat_i = cnt_q;

   counter_timer_ctrl #(.WIDTH(WIDTH), .PSC_WIDTH(PSC_WIDTH)) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .start_i    (start_i),
      .stop_i     (stop_i),
      .clear_i    (clear_i),
      .mode_i     (mode_i),
      .load_val_i (load_val_i),
      .term_val_i (term_val_i),
      .psc_i      (psc_i),
      .irq_ack_i  (irq_ack_i),
      .cnt_dat_i  (cnt_dat_i),
      .cnt_clr_o  (cnt_clr_o),
      .cnt_en_o   (cnt_en_o),
      .cnt_we_o   (cnt_we_o),
      .cnt_dat_o  (cnt_dat_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .irq_o      (irq_o),
      .overrun_o  (overrun_o),
      .state_o    (state_o)
   );

   logic [14:0] obs;
   assign obs = {cnt_clr_o, cnt_en_o, cnt_we_o, busy_o, done_o, irq_o, overrun_o, cnt_dat_o};

   // flags = {clr, en, we, busy, done, irq, ovr}
   function automatic logic [14:0] pk(input logic [6:0] flags, input logic [7:0] dat);
      return {flags, dat};
   endfunction

   task automatic idle_inputs();
      start_i   = 1'b0;
      stop_i    = 1'b0;
      clear_i   = 1'b0;
      irq_ack_i = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n_i = 1'b0;
      #3;
      vec_cnt++;
      if (obs !== 15'h0) begin
         miscmp++;
         $display("FAIL reset_outputs got=%h exp=%h", obs, 15'h0);
      end
      vec_cnt++;
      if (state_o !== 2'd0) begin
         miscmp++;
         $display("FAIL reset_state got=%0d exp=0", state_o);
      end
      @(negedge clk_i);
      rst_n_i = 1'b1;
   endtask

   task automatic test_oneshot();
      logic [14:0] e [9];
      e = '{pk(7'b0000000, 8'h00), pk(7'b0011000, 8'h03), pk(7'b0101000, 8'h00),
            pk(7'b0101000, 8'h00), pk(7'b0001000, 8'h00), pk(7'b0000110, 8'h00),
            pk(7'b0000010, 8'h00), pk(7'b0000010, 8'h00), pk(7'b0000000, 8'h00)};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk_i);
         idle_inputs();
         if (i == 0) begin
            start_i = 1'b1; mode_i = 1'b0; load_val_i = 8'h03; term_val_i = 8'h05; psc_i = 4'd0;
         end
         irq_ack_i = (i == 7);
         #1;
         vec_cnt++;
         if (obs !== e[i]) begin
            miscmp++;
            $display("FAIL oneshot_c%0d got=%h exp=%h", i, obs, e[i]);
         end
      end
      vec_cnt++;
      if (cnt_q !== 8'h05) begin
         miscmp++;
         $display("FAIL oneshot_count got=%h exp=05", cnt_q);
      end
      idle_inputs();
   endtask

   task automatic test_periodic();
      logic [14:0] e [20];
      e = '{pk(7'b0000000, 8'h00), pk(7'b0011000, 8'h00), pk(7'b0001000, 8'h00),
            pk(7'b0101000, 8'h00), pk(7'b0001000, 8'h00), pk(7'b0101000, 8'h00),
            pk(7'b0001000, 8'h00), pk(7'b0011000, 8'h00), pk(7'b0001010, 8'h00),
            pk(7'b0101010, 8'h00), pk(7'b0001010, 8'h00), pk(7'b0101010, 8'h00),
            pk(7'b0001010, 8'h00), pk(7'b0011010, 8'h00), pk(7'b0001011, 8'h00),
            pk(7'b0101011, 8'h00), pk(7'b0001000, 8'h00), pk(7'b0001000, 8'h00),
            pk(7'b0000000, 8'h00), pk(7'b0000000, 8'h00)};
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         idle_inputs();
         if (i == 0) begin
            start_i = 1'b1; mode_i = 1'b1; load_val_i = 8'h00; term_val_i = 8'h02; psc_i = 4'd1;
         end
         // Config changes after start must not reach the reload value.
         if (i == 3) begin
            load_val_i = 8'h77; term_val_i = 8'h33; psc_i = 4'd7; mode_i = 1'b0;
         end
         irq_ack_i = (i == 15);
         stop_i    = (i == 17);
         #1;
         vec_cnt++;
         if (obs !== e[i]) begin
            miscmp++;
            $display("FAIL periodic_c%0d got=%h exp=%h", i, obs, e[i]);
         end
      end
      vec_cnt++;
      if (cnt_q !== 8'h01) begin
         miscmp++;
         $display("FAIL stop_holds_count got=%h exp=01", cnt_q);
      end
      idle_inputs();
   endtask

   task automatic test_start_stop_clear();
      @(negedge clk_i);
      idle_inputs();
      start_i = 1'b1; stop_i = 1'b1;
      #1;
      vec_cnt++;
      if (obs !== 15'h0) begin
         miscmp++;
         $display("FAIL startstop_c0 got=%h exp=%h", obs, 15'h0);
      end
      @(negedge clk_i);
      idle_inputs();
      #1;
      vec_cnt++;
      if ({state_o, obs} !== 17'h0) begin
         miscmp++;
         $display("FAIL startstop_stay_idle got=%h exp=%h", {state_o, obs}, 17'h0);
      end
      @(negedge clk_i);
      clear_i = 1'b1;
      #1;
      vec_cnt++;
      if (obs !== pk(7'b1000000, 8'h00)) begin
         miscmp++;
         $display("FAIL clear_idle got=%h exp=%h", obs, pk(7'b1000000, 8'h00));
      end
      @(negedge clk_i);
      clear_i = 1'b0;
      #1;
      vec_cnt++;
      if ({cnt_q, obs} !== 23'h0) begin
         miscmp++;
         $display("FAIL clear_count got=%h exp=%h", {cnt_q, obs}, 23'h0);
      end
   endtask

   task automatic test_wrap();
      logic [14:0] e [9];
      logic [7:0]  c [4];
      e = '{pk(7'b0000000, 8'h00), pk(7'b0011000, 8'hFE), pk(7'b0101000, 8'h00),
            pk(7'b0101000, 8'h00), pk(7'b0101000, 8'h00), pk(7'b0001000, 8'h00),
            pk(7'b0000110, 8'h00), pk(7'b0000010, 8'h00), pk(7'b0000000, 8'h00)};
      c = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk_i);
         idle_inputs();
         if (i == 0) begin
            start_i = 1'b1; mode_i = 1'b0; load_val_i = 8'hFE; term_val_i = 8'h01; psc_i = 4'd0;
         end
         irq_ack_i = (i == 7);
         #1;
         vec_cnt++;
         if (obs !== e[i]) begin
            miscmp++;
            $display("FAIL wrap_c%0d got=%h exp=%h", i, obs, e[i]);
         end
         if (i >= 2 && i <= 5) begin
            vec_cnt++;
            if (cnt_q !== c[i-2]) begin
               miscmp++;
               $display("FAIL wrap_count_c%0d got=%h exp=%h", i, cnt_q, c[i-2]);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [14:0] e [11];
      e = '{pk(7'b0000000, 8'h00), pk(7'b0011000, 8'h05), pk(7'b0001000, 8'h00),
            pk(7'b0001000, 8'h00), pk(7'b0001000, 8'h00), pk(7'b0000110, 8'h00),
            pk(7'b0011010, 8'h09), pk(7'b0001010, 8'h00), pk(7'b0000111, 8'h00),
            pk(7'b0000011, 8'h00), pk(7'b0000000, 8'h00)};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk_i);
         idle_inputs();
         if (i == 0) begin
            start_i = 1'b1; mode_i = 1'b0; load_val_i = 8'h05; term_val_i = 8'h05; psc_i = 4'd2;
         end
         if (i == 5) begin
            start_i = 1'b1; load_val_i = 8'h09; term_val_i = 8'h09; psc_i = 4'd0;
         end
         irq_ack_i = (i == 9);
         #1;
         vec_cnt++;
         if (obs !== e[i]) begin
            miscmp++;
            $display("FAIL b2b_c%0d got=%h exp=%h", i, obs, e[i]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_ack_coincide();
      logic [14:0] e [7];
      e = '{pk(7'b0000000, 8'h00), pk(7'b0011000, 8'h00), pk(7'b0011000, 8'h00),
            pk(7'b0011010, 8'h00), pk(7'b0001010, 8'h00), pk(7'b0000010, 8'h00),
            pk(7'b0000000, 8'h00)};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_i);
         idle_inputs();
         if (i == 0) begin
            start_i = 1'b1; mode_i = 1'b1; load_val_i = 8'h00; term_val_i = 8'h00; psc_i = 4'd0;
         end
         irq_ack_i = (i == 3) || (i == 5);
         stop_i    = (i == 4);
         #1;
         vec_cnt++;
         if (obs !== e[i]) begin
            miscmp++;
            $display("FAIL ackcoin_c%0d got=%h exp=%h", i, obs, e[i]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_run();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         idle_inputs();
         if (i == 0) begin
            start_i = 1'b1; mode_i = 1'b0; load_val_i = 8'h00; term_val_i = 8'hFF; psc_i = 4'd0;
         end
      end
      #1;
      vec_cnt++;
      if (obs !== pk(7'b0101000, 8'h00)) begin
         miscmp++;
         $display("FAIL rstmid_running got=%h exp=%h", obs, pk(7'b0101000, 8'h00));
      end
      #1;
      rst_n_i = 1'b0;
      #1;
      vec_cnt++;
      if ({state_o, obs} !== 17'h0) begin
         miscmp++;
         $display("FAIL rstmid_async got=%h exp=%h", {state_o, obs}, 17'h0);
      end
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      #1;
      vec_cnt++;
      if ({state_o, obs} !== 17'h0) begin
         miscmp++;
         $display("FAIL rstmid_after got=%h exp=%h", {state_o, obs}, 17'h0);
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_start_stop_clear();
      test_wrap();
      test_back_to_back();
      test_ack_coincide();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end

endmodule
